// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback select stage.
package rf_wb_pkg;

  typedef enum logic [0:0] {
    WB_IDLE,
    WB_WAIT_IO
  } wb_state_t;

  localparam int unsigned IO_SRC = 0;

endpackage

// File: rtl/wb_io_fifo.sv
// Small synchronous FIFO buffering I/O input words for writeback source 0.
module wb_io_fifo #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int unsigned PtrW = $clog2(IO_DEPTH);
  localparam int unsigned CntW = $clog2(IO_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [IO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CntW'(IO_DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop happens in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/rf_wb_select.sv
// Writeback source select with I/O FIFO, I/O stall handling and a registered RF write port.
module rf_wb_select
  import rf_wb_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NSRC     = 4,
  parameter int unsigned IO_DEPTH = 4,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned SEL_W    = $clog2(NSRC)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NSRC*DATA_W-1:0] src_data_i,
  input  logic                   wb_en_i,
  input  logic [SEL_W-1:0]       wb_sel_i,
  input  logic [ADDR_W-1:0]      wb_rd_i,
  input  logic [DATA_W-1:0]      io_data_i,
  input  logic                   io_valid_i,
  output logic                   io_ready_o,
  output logic                   stall_o,
  output logic                   rf_we_o,
  output logic [ADDR_W-1:0]      rf_waddr_o,
  output logic [DATA_W-1:0]      rf_wdata_o,
  output logic                   sel_err_o
);

  wb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] sel_data;
  logic              stall;

  assign io_ready_o = ~fifo_full & ~rst_i;
  assign fifo_push  = io_valid_i & io_ready_o;

  wb_io_fifo #(
    .DATA_W  (DATA_W),
    .IO_DEPTH(IO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (fifo_push),
    .data_i (io_data_i),
    .pop_i  (fifo_pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (wb_sel_i == SEL_W'(i)) begin
        sel_data = src_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    err_d    = 1'b0;
    fifo_pop = 1'b0;
    stall    = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (wb_en_i) begin
          if (32'(wb_sel_i) >= NSRC) begin
            err_d = 1'b1;
          end else if (32'(wb_sel_i) == IO_SRC) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              we_d     = (wb_rd_i != '0);
              waddr_d  = wb_rd_i;
              wdata_d  = fifo_head;
            end else begin
              rd_d    = wb_rd_i;
              stall   = 1'b1;
              state_d = WB_WAIT_IO;
            end
          end else begin
            we_d    = (wb_rd_i != '0);
            waddr_d = wb_rd_i;
            wdata_d = sel_data;
          end
        end
      end
      WB_WAIT_IO: begin
        stall = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          we_d     = (rd_q != '0);
          waddr_d  = rd_q;
          wdata_d  = fifo_head;
          state_d  = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WB_IDLE;
      rd_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign stall_o    = stall & ~rst_i;
  assign rf_we_o    = we_q;
  assign rf_waddr_o = waddr_q;
  assign rf_wdata_o = wdata_q;
  assign sel_err_o  = err_q;

endmodule

// File: tb/tb_rf_wb_select.sv
// Directed table-driven bench for rf_wb_select with hand-written I/O FIFO sequences.
module tb_rf_wb_select;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NSRC     = 4;
  localparam int unsigned IO_DEPTH = 4;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned SEL_W    = 3;

  logic                   clk;
  logic                   rst;
  logic [NSRC*DATA_W-1:0] src_data;
  logic                   wb_en;
  logic [SEL_W-1:0]       wb_sel;
  logic [ADDR_W-1:0]      wb_rd;
  logic [DATA_W-1:0]      io_data;
  logic                   io_valid;
  logic                   io_ready;
  logic                   stall;
  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;
  logic                   sel_err;

  int total = 0;
  int bad   = 0;

  rf_wb_select #(
    .DATA_W  (DATA_W),
    .NSRC    (NSRC),
    .IO_DEPTH(IO_DEPTH),
    .ADDR_W  (ADDR_W),
    .SEL_W   (SEL_W)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .src_data_i(src_data),
    .wb_en_i   (wb_en),
    .wb_sel_i  (wb_sel),
    .wb_rd_i   (wb_rd),
    .io_data_i (io_data),
    .io_valid_i(io_valid),
    .io_ready_o(io_ready),
    .stall_o   (stall),
    .rf_we_o   (rf_we),
    .rf_waddr_o(rf_waddr),
    .rf_wdata_o(rf_wdata),
    .sel_err_o (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              en;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] rd;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              err;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    wb_en    = 1'b0;
    wb_sel   = '0;
    wb_rd    = '0;
    io_data  = '0;
    io_valid = 1'b0;
    src_data = {32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF, 32'h0BADF00D};

    // Reset
    tick();
    tick();
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_err", 32'(sel_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ready", 32'(io_ready), 32'd0);
    rst = 1'b0;
    settle();
    chk("post_rst_ready", 32'(io_ready), 32'd1);

    // Datapath sources, x0 suppression and select errors
    vecs[0] = '{1'b1, 3'd1, 5'd7,  1'b1, 5'd7,  32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 3'd2, 5'd9,  1'b1, 5'd9,  32'h12345678, 1'b0};
    vecs[2] = '{1'b1, 3'd3, 5'd31, 1'b1, 5'd31, 32'hCAFEF00D, 1'b0};
    vecs[3] = '{1'b1, 3'd2, 5'd0,  1'b0, 5'd0,  32'h12345678, 1'b0};
    vecs[4] = '{1'b1, 3'd5, 5'd4,  1'b0, 5'd0,  32'h12345678, 1'b1};
    vecs[5] = '{1'b0, 3'd1, 5'd8,  1'b0, 5'd0,  32'h12345678, 1'b0};
    vecs[6] = '{1'b1, 3'd7, 5'd2,  1'b0, 5'd0,  32'h12345678, 1'b1};
    vecs[7] = '{1'b1, 3'd1, 5'd1,  1'b1, 5'd1,  32'hDEADBEEF, 1'b0};
    for (int i = 0; i < 8; i++) begin
      wb_en  = vecs[i].en;
      wb_sel = vecs[i].sel;
      wb_rd  = vecs[i].rd;
      settle();
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
      tick();
      chk($sformatf("v%0d_we", i), 32'(rf_we), 32'(vecs[i].we));
      chk($sformatf("v%0d_waddr", i), 32'(rf_waddr), 32'(vecs[i].waddr));
      chk($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].wdata);
      chk($sformatf("v%0d_err", i), 32'(sel_err), 32'(vecs[i].err));
    end
    wb_en = 1'b0;
    tick();

    // I/O stall: request on empty FIFO, data arrives a cycle later
    wb_en = 1'b1; wb_sel = 3'd0; wb_rd = 5'd3;
    settle();
    chk("io_stall_req", 32'(stall), 32'd1);
    tick();
    wb_en = 1'b0; wb_sel = 3'd1; io_data = 32'h55; io_valid = 1'b1;
    settle();
    chk("io_stall_wait", 32'(stall), 32'd1);
    chk("io_no_we_wait", 32'(rf_we), 32'd0);
    tick();
    io_valid = 1'b0;
    settle();
    chk("io_stall_pop", 32'(stall), 32'd1);
    chk("io_no_we_pop", 32'(rf_we), 32'd0);
    tick();
    chk("io_we", 32'(rf_we), 32'd1);
    chk("io_waddr", 32'(rf_waddr), 32'd3);
    chk("io_wdata", rf_wdata, 32'h55);
    chk("io_stall_done", 32'(stall), 32'd0);
    tick();
    chk("io_we_pulse", 32'(rf_we), 32'd0);

    // Minimum stall: data arrives with the request
    wb_en = 1'b1; wb_sel = 3'd0; wb_rd = 5'd4; io_data = 32'h77; io_valid = 1'b1;
    settle();
    chk("min_stall_n", 32'(stall), 32'd1);
    tick();
    wb_en = 1'b0; io_valid = 1'b0;
    settle();
    chk("min_stall_n1", 32'(stall), 32'd1);
    tick();
    chk("min_we", 32'(rf_we), 32'd1);
    chk("min_waddr", 32'(rf_waddr), 32'd4);
    chk("min_wdata", rf_wdata, 32'h77);

    // Fill FIFO, then drain six words while pushing two more
    for (int k = 0; k < 4; k++) begin
      io_data = 32'(k + 1); io_valid = 1'b1;
      tick();
    end
    io_valid = 1'b0;
    settle();
    chk("full_ready", 32'(io_ready), 32'd0);
    begin
      int pushed;
      pushed = 4;
      for (int k = 0; k < 6; k++) begin
        wb_en = 1'b1; wb_sel = 3'd0; wb_rd = 5'(10 + k);
        io_valid = (pushed < 6);
        io_data  = 32'(pushed + 1);
        settle();
        chk($sformatf("wrap%0d_ready", k), 32'(io_ready), (k == 0) ? 32'd0 : 32'd1);
        chk($sformatf("wrap%0d_stall", k), 32'(stall), 32'd0);
        tick();
        if (k != 0 && pushed < 6) pushed++;
        chk($sformatf("wrap%0d_we", k), 32'(rf_we), 32'd1);
        chk($sformatf("wrap%0d_waddr", k), 32'(rf_waddr), 32'(10 + k));
        chk($sformatf("wrap%0d_wdata", k), rf_wdata, 32'(k + 1));
      end
    end
    wb_en = 1'b0; io_valid = 1'b0;
    tick();
    chk("wrap_idle_we", 32'(rf_we), 32'd0);

    // I/O write to x0 still pops the FIFO
    io_data = 32'hA5A5; io_valid = 1'b1;
    tick();
    io_valid = 1'b0;
    wb_en = 1'b1; wb_sel = 3'd0; wb_rd = 5'd0;
    settle();
    chk("x0io_stall", 32'(stall), 32'd0);
    tick();
    chk("x0io_we", 32'(rf_we), 32'd0);
    chk("x0io_waddr", 32'(rf_waddr), 32'd0);
    chk("x0io_wdata", rf_wdata, 32'hA5A5);
    wb_rd = 5'd6;
    settle();
    chk("x0io_popped", 32'(stall), 32'd1);
    tick();

    // Reset while waiting abandons the pending write
    wb_en = 1'b0;
    settle();
    chk("mid_wait_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    settle();
    chk("mid_rst_stall", 32'(stall), 32'd0);
    tick();
    rst = 1'b0;
    io_data = 32'h99; io_valid = 1'b1;
    settle();
    chk("mid_rel_stall", 32'(stall), 32'd0);
    chk("mid_rel_wdata", rf_wdata, 32'd0);
    tick();
    io_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mid_no_we%0d", k), 32'(rf_we), 32'd0);
      chk($sformatf("mid_no_stall%0d", k), 32'(stall), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
